// File: rtl/responder_core.sv
// Quiz responder: synchronised buttons, arm/lock/timeout/foul state machine,
// two-digit BCD countdown and a fixed-length buzzer pulse.
module responder_core #(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned INIT_H   = 3,
    parameter int unsigned INIT_L   = 0,
    parameter int unsigned BUZZ_LEN = 500
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Start,
    input  logic       Clear,
    input  logic [3:0] Player_Key,
    output logic [3:0] Player_Number,
    output logic [3:0] TimerH,
    output logic [3:0] TimerL,
    output logic       Locked,
    output logic       Timeout,
    output logic       Foul,
    output logic       Buzz
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BuzzW = $clog2(BUZZ_LEN + 1);
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [BuzzW-1:0] BuzzLoad = BuzzW'(BUZZ_LEN);
    localparam logic [3:0] InitH = 4'(INIT_H);
    localparam logic [3:0] InitL = 4'(INIT_L);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StLocked,
        StTimeout,
        StFoul
    } state_e;

    // Bit order of the synchroniser vector: {Clear, Start, Player_Key[3:0]}.
    logic [5:0] sync1_q, sync1_d;
    logic [5:0] sync2_q, sync2_d;
    logic [5:0] dly_q, dly_d;
    logic [5:0] evt;
    logic       clear_evt;
    logic       start_evt;
    logic [3:0] key_evt;
    logic [3:0] key_num;

    state_e           state_q, state_d;
    logic [3:0]       player_q, player_d;
    logic [3:0]       timer_h_q, timer_h_d;
    logic [3:0]       timer_l_q, timer_l_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [BuzzW-1:0] buzz_cnt_q, buzz_cnt_d;

    logic       step;
    logic       last_step;
    logic [3:0] dec_h;
    logic [3:0] dec_l;

    always_comb begin
        sync1_d = {Clear, Start, Player_Key};
        sync2_d = sync1_q;
        dly_d   = sync2_q;
    end

    assign evt       = sync2_q & ~dly_q;
    assign clear_evt = evt[5];
    assign start_evt = evt[4];
    assign key_evt   = evt[3:0];

    // Lowest-numbered key wins when several rise together.
    always_comb begin
        key_num = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            if (key_evt[i]) begin
                key_num = 4'(i + 1);
            end
        end
    end

    always_comb begin
        if (timer_l_q == 4'd0) begin
            dec_h = timer_h_q - 4'd1;
            dec_l = 4'd9;
        end else begin
            dec_h = timer_h_q;
            dec_l = timer_l_q - 4'd1;
        end
    end

    assign step      = (tick_q == TickLast);
    assign last_step = step && (timer_h_q == 4'd0) && (timer_l_q == 4'd1);

    always_comb begin
        state_d    = state_q;
        player_d   = player_q;
        timer_h_d  = timer_h_q;
        timer_l_d  = timer_l_q;
        tick_d     = '0;
        buzz_cnt_d = (buzz_cnt_q != '0) ? buzz_cnt_q - BuzzW'(1) : '0;

        if (clear_evt) begin
            state_d    = StIdle;
            player_d   = 4'd0;
            timer_h_d  = InitH;
            timer_l_d  = InitL;
            buzz_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|key_evt) begin
                        state_d    = StFoul;
                        player_d   = key_num;
                        buzz_cnt_d = BuzzLoad;
                    end else if (start_evt) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    // A key press beats a coincident countdown step.
                    if (|key_evt) begin
                        state_d    = StLocked;
                        player_d   = key_num;
                        buzz_cnt_d = BuzzLoad;
                    end else if (step) begin
                        timer_h_d = dec_h;
                        timer_l_d = dec_l;
                        if (last_step) begin
                            state_d    = StTimeout;
                            player_d   = 4'd0;
                            buzz_cnt_d = BuzzLoad;
                        end
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            dly_q      <= '0;
            state_q    <= StIdle;
            player_q   <= 4'd0;
            timer_h_q  <= InitH;
            timer_l_q  <= InitL;
            tick_q     <= '0;
            buzz_cnt_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            dly_q      <= dly_d;
            state_q    <= state_d;
            player_q   <= player_d;
            timer_h_q  <= timer_h_d;
            timer_l_q  <= timer_l_d;
            tick_q     <= tick_d;
            buzz_cnt_q <= buzz_cnt_d;
        end
    end

    assign Player_Number = player_q;
    assign TimerH        = timer_h_q;
    assign TimerL        = timer_l_q;
    assign Locked        = (state_q == StLocked);
    assign Timeout       = (state_q == StTimeout);
    assign Foul          = (state_q == StFoul);
    assign Buzz          = (buzz_cnt_q != '0);

endmodule

// File: tb/tb_responder_core.sv
// Directed and randomised checks of responder_core against a model kept as
// seconds remaining, a cycle count in ARMED and a history of sampled inputs.
module tb_responder_core;

    localparam int unsigned TD = 4;
    localparam int unsigned BL = 6;
    localparam int unsigned IH = 3;
    localparam int unsigned IL = 0;
    localparam int InitSecs = IH * 10 + IL;

    localparam int MIdle    = 0;
    localparam int MArmed   = 1;
    localparam int MLocked  = 2;
    localparam int MTimeout = 3;
    localparam int MFoul    = 4;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       Start = 1'b0;
    logic       Clear = 1'b0;
    logic [3:0] Player_Key = 4'd0;
    logic [3:0] Player_Number;
    logic [3:0] TimerH;
    logic [3:0] TimerL;
    logic       Locked;
    logic       Timeout;
    logic       Foul;
    logic       Buzz;

    logic [15:0] dut_vec;
    logic [15:0] rst_vec;

    int n_cmp = 0;
    int n_bad = 0;

    int m_state = MIdle;
    int m_secs = InitSecs;
    int m_player = 0;
    int m_buzz = 0;
    int m_ticks = 0;
    logic [5:0] hist[$];

    always #5 CLK = ~CLK;

    responder_core #(
        .TICK_DIV(TD),
        .INIT_H  (IH),
        .INIT_L  (IL),
        .BUZZ_LEN(BL)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .Start        (Start),
        .Clear        (Clear),
        .Player_Key   (Player_Key),
        .Player_Number(Player_Number),
        .TimerH       (TimerH),
        .TimerL       (TimerL),
        .Locked       (Locked),
        .Timeout      (Timeout),
        .Foul         (Foul),
        .Buzz         (Buzz)
    );

    assign dut_vec = {Player_Number, TimerH, TimerL, Locked, Timeout, Foul, Buzz};
    assign rst_vec = {4'd0, 4'(IH), 4'(IL), 4'b0000};

    function automatic int first_player(input logic [3:0] k);
        int p;
        p = 0;
        for (int i = 0; i < 4; i++) begin
            if (k[i] && p == 0) p = i + 1;
        end
        return p;
    endfunction

    function automatic logic [15:0] exp_vec();
        return {4'(m_player), 4'(m_secs / 10), 4'(m_secs % 10),
                m_state == MLocked, m_state == MTimeout, m_state == MFoul, m_buzz > 0};
    endfunction

    // An input seen at edge n-2 but not at edge n-3 acts at edge n.
    task automatic model_edge();
        logic [5:0] ev;
        int sz;
        if (!RSTn) begin
            m_state = MIdle;
            m_secs = InitSecs;
            m_player = 0;
            m_buzz = 0;
            m_ticks = 0;
            hist.delete();
            repeat (3) hist.push_back(6'd0);
            return;
        end
        sz = hist.size();
        ev = hist[sz-2] & ~hist[sz-3];
        hist.push_back({Clear, Start, Player_Key});
        void'(hist.pop_front());
        if (m_buzz > 0) m_buzz--;
        if (ev[5]) begin
            m_state = MIdle;
            m_secs = InitSecs;
            m_player = 0;
            m_buzz = 0;
        end else if (m_state == MIdle) begin
            if (ev[3:0] != 4'd0) begin
                m_state = MFoul;
                m_player = first_player(ev[3:0]);
                m_buzz = BL;
            end else if (ev[4]) begin
                m_state = MArmed;
                m_ticks = 0;
            end
        end else if (m_state == MArmed) begin
            if (ev[3:0] != 4'd0) begin
                m_state = MLocked;
                m_player = first_player(ev[3:0]);
                m_buzz = BL;
            end else begin
                m_ticks++;
                if (m_ticks == TD) begin
                    m_ticks = 0;
                    m_secs--;
                    if (m_secs == 0) begin
                        m_state = MTimeout;
                        m_player = 0;
                        m_buzz = BL;
                    end
                end
            end
        end
    endtask

    always @(posedge CLK) model_edge();

    task automatic test_reset();
        Start = 1'($urandom);
        Clear = 1'($urandom);
        Player_Key = 4'($urandom);
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (dut_vec !== rst_vec) begin
            n_bad++;
            $display("FAIL reset_values: got %h expected %h", dut_vec, rst_vec);
        end
        Start = 1'b0;
        Clear = 1'b0;
        Player_Key = 4'd0;
        RSTn = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            n_cmp++;
            if (dut_vec !== rst_vec) begin
                n_bad++;
                $display("FAIL reset_idle: got %h expected %h", dut_vec, rst_vec);
            end
        end
    endtask

    task automatic test_countdown();
        int buzz_n;
        bit saw_to;
        buzz_n = 0;
        saw_to = 0;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        for (int c = 0; c < TD * InitSecs + BL + 20; c++) begin
            @(negedge CLK);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL countdown cyc %0d: got %h expected %h", c, dut_vec, exp_vec());
            end
            if (Buzz) buzz_n++;
            if (Timeout) saw_to = 1;
        end
        n_cmp++;
        if (!saw_to || {TimerH, TimerL, Player_Number} !== 12'h000) begin
            n_bad++;
            $display("FAIL timeout_end: got to=%0d timer=%h%h pn=%0d expected to=1 timer=00 pn=0",
                     saw_to, TimerH, TimerL, Player_Number);
        end
        n_cmp++;
        if (buzz_n != BL) begin
            n_bad++;
            $display("FAIL timeout_buzz_len: got %0d expected %0d", buzz_n, BL);
        end
    endtask

    task automatic test_lock_27();
        bit found;
        int buzz_n;
        Clear = 1'b1;
        @(negedge CLK);
        Clear = 1'b0;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (m_state == MArmed && m_secs == 27) begin
                found = 1;
                break;
            end
        end
        n_cmp++;
        if (!found || {TimerH, TimerL} !== 8'h27) begin
            n_bad++;
            $display("FAIL lock_reach_27: got found=%0d timer=%h%h expected 27", found, TimerH,
                     TimerL);
        end
        Player_Key = 4'b0100;
        buzz_n = 0;
        for (int c = 0; c < BL + 6; c++) begin
            @(negedge CLK);
            if (c == 1) Player_Key = 4'd0;
            if (Buzz) buzz_n++;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL lock_track: got %h expected %h", dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if ({Player_Number, TimerH, TimerL, Locked, Timeout, Foul} !== {12'h327, 3'b100}) begin
            n_bad++;
            $display("FAIL lock_p3_27: got pn=%0d timer=%h%h L=%b expected pn=3 timer=27 L=1",
                     Player_Number, TimerH, TimerL, Locked);
        end
        n_cmp++;
        if (buzz_n != BL) begin
            n_bad++;
            $display("FAIL lock_buzz_len: got %0d expected %0d", buzz_n, BL);
        end
        Player_Key = 4'b0001;
        repeat (2) @(negedge CLK);
        Player_Key = 4'd0;
        repeat (6) @(negedge CLK);
        n_cmp++;
        if ({Player_Number, TimerH, TimerL, Locked, Buzz} !== {12'h327, 2'b10}) begin
            n_bad++;
            $display("FAIL lock_ignore_key: got pn=%0d timer=%h%h L=%b B=%b expected 3/27/1/0",
                     Player_Number, TimerH, TimerL, Locked, Buzz);
        end
    endtask

    task automatic test_simul_keys();
        logic [3:0] k;
        int want;
        for (int t = 0; t < 9; t++) begin
            k = (t == 0) ? 4'b1010 : 4'($urandom_range(1, 15));
            want = 0;
            while (k[want] == 1'b0) want++;
            want++;
            Clear = 1'b1;
            @(negedge CLK);
            Clear = 1'b0;
            Start = 1'b1;
            @(negedge CLK);
            Start = 1'b0;
            repeat ($urandom_range(3, 12)) @(negedge CLK);
            Player_Key = k;
            repeat (5) begin
                @(negedge CLK);
                n_cmp++;
                if (dut_vec !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL simul_track k=%b: got %h expected %h", k, dut_vec, exp_vec());
                end
            end
            Player_Key = 4'd0;
            n_cmp++;
            if (Player_Number !== 4'(want) || Locked !== 1'b1) begin
                n_bad++;
                $display("FAIL simul_lowest k=%b: got pn=%0d L=%b expected pn=%0d L=1", k,
                         Player_Number, Locked, want);
            end
        end
    endtask

    task automatic test_foul();
        Clear = 1'b1;
        @(negedge CLK);
        Clear = 1'b0;
        repeat (4) @(negedge CLK);
        Player_Key = 4'b1000;
        repeat (4) @(negedge CLK);
        Player_Key = 4'd0;
        n_cmp++;
        if ({Player_Number, Foul, Locked, Timeout, Buzz} !== {4'd4, 4'b1001}) begin
            n_bad++;
            $display("FAIL foul_p4: got pn=%0d F=%b L=%b T=%b B=%b expected 4/1/0/0/1",
                     Player_Number, Foul, Locked, Timeout, Buzz);
        end
        Clear = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            Clear = 1'b0;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL foul_clear_track: got %h expected %h", dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (dut_vec !== rst_vec) begin
            n_bad++;
            $display("FAIL foul_cleared: got %h expected %h", dut_vec, rst_vec);
        end
    endtask

    task automatic test_step_collision();
        bit found;
        Clear = 1'b1;
        @(negedge CLK);
        Clear = 1'b0;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (m_state == MArmed && m_secs == 10) begin
                found = 1;
                break;
            end
        end
        @(negedge CLK);
        Player_Key = 4'b0001;
        repeat (6) @(negedge CLK);
        Player_Key = 4'd0;
        n_cmp++;
        if (!found || {Player_Number, TimerH, TimerL, Locked} !== {12'h110, 1'b1}) begin
            n_bad++;
            $display("FAIL collide_lock_10: got found=%0d pn=%0d timer=%h%h L=%b expected 1/10/1",
                     found, Player_Number, TimerH, TimerL, Locked);
        end
        repeat (BL) @(negedge CLK);
        Clear = 1'b1;
        Start = 1'b1;
        @(negedge CLK);
        Clear = 1'b0;
        Start = 1'b0;
        for (int c = 0; c < 3 * TD + 6; c++) begin
            @(negedge CLK);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL clear_start_track: got %h expected %h", dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (dut_vec !== rst_vec) begin
            n_bad++;
            $display("FAIL clear_start_idle: got %h expected %h", dut_vec, rst_vec);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        Clear = 1'b1;
        @(negedge CLK);
        Clear = 1'b0;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (m_state == MArmed && m_secs == 15) begin
                found = 1;
                break;
            end
        end
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        n_cmp++;
        if (!found || dut_vec !== rst_vec) begin
            n_bad++;
            $display("FAIL midreset_values: got found=%0d vec=%h expected %h", found, dut_vec,
                     rst_vec);
        end
        repeat (4 * TD) @(negedge CLK);
        n_cmp++;
        if (dut_vec !== rst_vec) begin
            n_bad++;
            $display("FAIL midreset_hold: got %h expected %h", dut_vec, rst_vec);
        end
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        for (int c = 0; c < 4 * TD; c++) begin
            @(negedge CLK);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL midreset_restart: got %h expected %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_key_through_reset();
        Player_Key = 4'b0010;
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if (Foul !== 1'b0 || Player_Number !== 4'd0) begin
            n_bad++;
            $display("FAIL held_key_early: got F=%b pn=%0d expected 0/0", Foul, Player_Number);
        end
        @(negedge CLK);
        n_cmp++;
        if (Foul !== 1'b1 || Player_Number !== 4'd2 || Buzz !== 1'b1) begin
            n_bad++;
            $display("FAIL held_key_foul: got F=%b pn=%0d B=%b expected 1/2/1", Foul,
                     Player_Number, Buzz);
        end
        Player_Key = 4'd0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %h expected %h", c, dut_vec, exp_vec());
            end
            RSTn = ($urandom_range(0, 399) != 0);
            Clear = ($urandom_range(0, 59) == 0);
            Start = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 4; i++) Player_Key[i] = ($urandom_range(0, 39) == 0);
        end
        RSTn = 1'b1;
        Clear = 1'b0;
        Start = 1'b0;
        Player_Key = 4'd0;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_lock_27();
        test_simul_keys();
        test_foul();
        test_step_collision();
        test_reset_mid();
        test_key_through_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/responder_core.md
RESPONDER_CORE -- requirements
Module: responder_core

Interface
REQ-001 Parameter TICK_DIV, default 1000, CLK cycles per countdown step (one second on the board clock).
REQ-002 Parameter INIT_H, default 3, initial countdown tens digit in BCD, range 0-9.
REQ-003 Parameter INIT_L, default 0, initial countdown units digit in BCD, range 0-9; INIT_H:INIT_L SHALL NOT be 00.
REQ-004 Parameter BUZZ_LEN, default 500, Buzz pulse length in CLK cycles, >=1.
REQ-005 CLK  input  1  single clock; all flops SHALL be clocked on its rising edge.
REQ-006 RSTn  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
REQ-007 Start  input  1  host arm button, asynchronous, level, debounced externally.
REQ-008 Clear  input  1  host clear button, asynchronous, level, debounced externally.
REQ-009 Player_Key  input  4  player buttons, bit i = player i+1, active-high, asynchronous, debounced externally.
REQ-010 Player_Number  output  4  winning or fouling player: 0 = none, 1-4 = player.
REQ-011 TimerH  output  4  countdown tens digit, BCD 0-9.
REQ-012 TimerL  output  4  countdown units digit, BCD 0-9.
REQ-013 Locked  output  1  high while in LOCKED.
REQ-014 Timeout  output  1  high while in TIMEOUT.
REQ-015 Foul  output  1  high while in FOUL.
REQ-016 Buzz  output  1  buzzer drive, active-high pulse.

Function
REQ-017 Each of Start, Clear and Player_Key[3:0] SHALL pass through a two-flop synchronizer followed by a delay flop; an event is sync-stage-2 high and delay flop low (rising edge).
REQ-018 An input first held high before CLK edge k SHALL take effect in the state registered at edge k+2, visible after 3 CLK rising edges.
REQ-019 States SHALL be IDLE, ARMED, LOCKED, TIMEOUT and FOUL, encoded in one registered state variable.
REQ-020 A Clear event SHALL, from any state, go to IDLE, load TimerH:TimerL = INIT_H:INIT_L, and set Player_Number = 0.
REQ-021 IDLE, Start event, no key event -> ARMED; tick counter cleared to 0.
REQ-022 IDLE, any key event -> FOUL, Player_Number = index of the lowest-numbered key with an event, +1; any Start event in that cycle is ignored.
REQ-023 ARMED, any key event -> LOCKED, Player_Number = lowest-numbered key with an event, +1; timer frozen at its current value.
REQ-024 ARMED, tick counter SHALL count 0..TICK_DIV-1 and wrap; each wrap is a step that decrements the BCD timer.
REQ-025 A BCD decrement SHALL set TimerL to 9 and decrement TimerH when TimerL = 0; otherwise it decrements TimerL.
REQ-026 A step taking the timer from 01 to 00 SHALL enter TIMEOUT in the same cycle, with Player_Number = 0.
REQ-027 If a key event and a step coincide in ARMED, the key event wins: LOCKED, and the timer keeps its pre-step value.
REQ-028 LOCKED, TIMEOUT and FOUL are terminal; only Clear or reset exits them, and Start and key events there are ignored.
REQ-029 If Clear and any other event coincide, Clear wins.
REQ-030 Start events while ARMED are ignored; the countdown does not restart.
REQ-031 Entering LOCKED, TIMEOUT or FOUL SHALL raise Buzz for exactly BUZZ_LEN cycles, starting the cycle that state is registered.
REQ-032 A Clear event during an active Buzz pulse SHALL drop Buzz in the same cycle the state returns to IDLE.
REQ-033 The tick counter SHALL hold at 0 outside ARMED.
REQ-034 TimerH and TimerL SHALL never hold a value above 9.
REQ-035 Locked, Timeout and Foul SHALL be decoded directly from the state register, and at most one is high at any time.

Reset
REQ-036 RSTn low at a CLK edge SHALL set, at that edge: state IDLE, Player_Number 0, TimerH INIT_H, TimerL INIT_L, Locked/Timeout/Foul/Buzz 0, tick counter 0, all synchronizer and delay flops 0.
REQ-037 Reset asserted mid-countdown or mid-Buzz SHALL abort it with no residual pulse after release.
REQ-038 A key held through reset release SHALL produce an event 3 CLK edges after release (FOUL), because the delay flops reset to 0.

Verification
REQ-039 Reset, Start pulse, no keys, TICK_DIV=4 -> ARMED; timer 30,29,...,01,00 with one step every 4 cycles; TIMEOUT at 00; Buzz high for BUZZ_LEN cycles; Player_Number 0.
REQ-040 ARMED at timer 27, Player_Key=4'b0100 -> Player_Number 3, Locked 1, timer frozen at 27, Buzz pulse; later Player_Key=4'b0001 is ignored.
REQ-041 ARMED, Player_Key 4'b1010 rising in the same cycle -> Player_Number 2 (lowest index wins).
REQ-042 IDLE, Player_Key=4'b1000 -> FOUL, Player_Number 4, Foul 1; then Clear -> IDLE, timer 30, all flags 0.
REQ-043 Key event in the same cycle as the step 10->09 -> LOCKED with timer 10; Clear and Start together in IDLE -> stays IDLE.
REQ-044 RSTn low for one edge during ARMED at timer 15 with Buzz idle -> all outputs at reset values on the next cycle; no state change until a new Start event.
